fsm_counter_core: RTL and testbench
===================================

# fsm_counter_core

Run-controlled counting core that executes one job of a programmable length and reports completion. It is the execution stage driven by the team's IDLE/RUN/DONE control FSM: it accepts a one-cycle run request with a cycle count, and counts through that many cycles. It then raises the single-cycle done indication that serves as the control FSM's `is_done` input. It also exposes the running count with a valid strobe so downstream logic can consume one item per run cycle.

## Interface
- `CNT_WIDTH`, default 7: width of the requested count and of the running counter.

- `clk`  in  1  clock; all state changes on rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on rising edge of `clk`.
- `i_run`  in  1  run request; sampled only in IDLE.
- `i_num_cnt`  in  CNT_WIDTH  number of run cycles N; captured with `i_run`.
- `o_idle`  out  1  high while in IDLE.
- `o_running`  out  1  high while in RUN.
- `o_done`  out  1  high for exactly one cycle in DONE.
- `o_cnt_val`  out  CNT_WIDTH  current count, 0..N-1 during RUN.
- `o_cnt_valid`  out  1  high while `o_cnt_val` is meaningful (equal to `o_running`).

## Operation
- Three-state FSM, 2-bit encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10. The unused code 2'b11 returns to IDLE on the next edge.
- Separate registered state, combinational next-state, and combinational (Moore) output decode. Every combinational path has a default assignment, so no latches.
- **IDLE**
  - If `i_run`=1 and `i_num_cnt`≠0: capture `i_num_cnt` into `num_cnt_r`, clear `cnt`, go to RUN.
  - If `i_run`=1 and `i_num_cnt`=0: go directly to DONE. No RUN cycles; `o_cnt_valid` is never asserted.
  - If `i_run`=0: stay in IDLE.
- **RUN**
  - `o_cnt_val`=`cnt`, `o_cnt_valid`=1.
  - Internal `is_done` = (`cnt` == `num_cnt_r`-1).
  - If `is_done`: go to DONE and clear `cnt`.
  - Otherwise: `cnt` ← `cnt`+1.
- **DONE**
  - `o_done`=1 for one cycle, then unconditionally go to IDLE.
- `i_run` is ignored in RUN and DONE. Requests are neither queued nor extended.
- `i_num_cnt` changes outside the capture edge have no effect on a job in progress.
- Width and arithmetic rules:
  - `cnt` and `num_cnt_r` are both CNT_WIDTH bits.
  - Maximum N = 2^CNT_WIDTH-1. `cnt` peaks at N-1 ≤ 2^CNT_WIDTH-2, so it never wraps.
  - `num_cnt_r`-1 is evaluated only in RUN, where `num_cnt_r` ≥ 1, so it never underflows.
- Output values:
  - `o_idle`, `o_running` and `o_done` are mutually exclusive (one-hot).
  - `o_cnt_val`=0 outside RUN.

## Timing
- Reset: on any rising edge with `reset_n`=0:
  - state=IDLE, `cnt`=0, `num_cnt_r`=0.
  - Outputs from the following cycle: `o_idle`=1, `o_running`=0, `o_done`=0, `o_cnt_val`=0, `o_cnt_valid`=0.
- Reset has priority over `i_run` on the same edge.
- Reset during RUN or DONE aborts the job; no `o_done` is produced for it.
- Job timeline, with `i_run` high in cycle 0 and N≥1:
  - Cycles 1..N: RUN, with `o_cnt_val` = 0, 1, …, N-1.
  - Cycle N+1: DONE, `o_done`=1.
  - Cycle N+2: IDLE.
- Latency from the `i_run` cycle to `o_done` is N+1 cycles.
- N=0: cycle 1 is DONE, cycle 2 is IDLE.
- Back-to-back: a new `i_run` is accepted earliest in cycle N+2, giving a next RUN in cycle N+3. Minimum job period is N+2 cycles.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 edges with `i_run`=1 → `o_idle`=1, all other outputs 0. Release; with `i_run`=0, the block stays IDLE.
- **Basic job:** `i_num_cnt`=5, `i_run` pulse in cycle 0 → `o_running`/`o_cnt_valid` high in cycles 1–5 with `o_cnt_val` 0,1,2,3,4. `o_done`=1 in cycle 6 only. `o_idle`=1 in cycle 7.
- **Boundary counts:**
  - N=0 → `o_done` in cycle 1, `o_cnt_valid` never high.
  - N=1 → single RUN cycle with `o_cnt_val`=0, `o_done` in cycle 2.
  - N=127 with CNT_WIDTH=7 → last `o_cnt_val`=126, `o_done` in cycle 128, no wrap.
- **Ignored requests:** start N=4. Hold `i_run`=1 and set `i_num_cnt`=9 throughout RUN and DONE → job still lasts 4 cycles. A new job with N=9 starts only because `i_run` is still high in the IDLE cycle; its RUN begins two cycles after DONE.
- **Back-to-back:** `i_run` held high with N=2 → repeating pattern RUN, RUN, DONE, IDLE, with a period of 4 cycles.
- **Abort:** start N=10 and assert `reset_n`=0 at RUN cycle 3 → IDLE on the next cycle, `o_cnt_val`=0, no `o_done`. A subsequent N=3 job completes normally.

Source files
------------

// File: rtl/fsm_counter_core_if.sv
// Bundles the run request, job length, status and count stream of
// fsm_counter_core.
//   master : drives i_run / i_num_cnt and observes status and count outputs
//   slave  : the counting core itself
interface fsm_counter_core_if #(
  parameter int CNT_WIDTH = 7
);
  logic                 i_run;
  logic [CNT_WIDTH-1:0] i_num_cnt;
  logic                 o_idle;
  logic                 o_running;
  logic                 o_done;
  logic [CNT_WIDTH-1:0] o_cnt_val;
  logic                 o_cnt_valid;

  modport master (
    output i_run, i_num_cnt,
    input  o_idle, o_running, o_done, o_cnt_val, o_cnt_valid
  );

  modport slave (
    input  i_run, i_num_cnt,
    output o_idle, o_running, o_done, o_cnt_val, o_cnt_valid
  );
endinterface

// File: rtl/fsm_counter_core.sv
// Run-controlled counting core. A one-cycle request in IDLE starts a job of
// i_num_cnt cycles; during RUN the running count is streamed with a valid
// strobe, then DONE pulses for one cycle before returning to IDLE.
// Ports:
//   clk     : clock, all state changes on the rising edge
//   reset_n : synchronous active-low reset
//   bus     : slave side of fsm_counter_core_if (request, status, count)
module fsm_counter_core #(
  parameter int CNT_WIDTH = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  fsm_counter_core_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] num_cnt_r;
  logic [CNT_WIDTH-1:0] num_cnt_next;
  logic                 is_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      num_cnt_r <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      num_cnt_r <= num_cnt_next;
    end
  end

  // Only consulted in RUN, where num_cnt_r >= 1, so the decrement never wraps.
  assign is_done = (cnt == (num_cnt_r - CNT_WIDTH'(1)));

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    num_cnt_next = num_cnt_r;
    case (state)
      IDLE: begin
        if (bus.i_run) begin
          if (bus.i_num_cnt != '0) begin
            num_cnt_next = bus.i_num_cnt;
            cnt_next     = '0;
            state_next   = RUN;
          end else begin
            state_next   = DONE;
          end
        end
      end
      RUN: begin
        if (is_done) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next   = cnt + CNT_WIDTH'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        // The unused encoding 2'b11 recovers to IDLE.
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    bus.o_idle      = 1'b0;
    bus.o_running   = 1'b0;
    bus.o_done      = 1'b0;
    bus.o_cnt_val   = '0;
    bus.o_cnt_valid = 1'b0;
    case (state)
      IDLE: bus.o_idle = 1'b1;
      RUN: begin
        bus.o_running   = 1'b1;
        bus.o_cnt_valid = 1'b1;
        bus.o_cnt_val   = cnt;
      end
      DONE: bus.o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_counter_core.sv
module tb_fsm_counter_core;

  localparam int CW = 7;

  // {idle, running, done, cnt_valid, cnt_val}
  typedef struct packed {
    logic          idle;
    logic          running;
    logic          done;
    logic          valid;
    logic [CW-1:0] val;
  } rec_t;

  typedef struct {
    logic          rst_n;
    logic          run;
    logic [CW-1:0] n;
    logic          chk;
    rec_t          exp;
  } vec_t;

  localparam rec_t IDLE_REC = '{idle: 1'b1, running: 1'b0, done: 1'b0, valid: 1'b0, val: '0};
  localparam rec_t DONE_REC = '{idle: 1'b0, running: 1'b0, done: 1'b1, valid: 1'b0, val: '0};

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fsm_counter_core_if #(.CNT_WIDTH(CW)) bus ();

  fsm_counter_core #(.CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mdl_on   = 1'b0;
  rec_t s;          // outputs sampled in the current cycle
  rec_t exp_cur;    // model's expected outputs for the current cycle
  rec_t exp_q[$];   // model's pending outputs for the job in flight

  function automatic rec_t run_rec(input int v);
    rec_t r;
    r = '{idle: 1'b0, running: 1'b1, done: 1'b0, valid: 1'b1, val: CW'(v)};
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: sample outputs away from the active edge, compare with
  // the model, then apply this cycle's inputs and advance the model.
  task automatic cycle(input logic run, input logic [CW-1:0] n, input logic rst_n_in);
    @(negedge clk);
    s = {bus.o_idle, bus.o_running, bus.o_done, bus.o_cnt_valid, bus.o_cnt_val};
    if (mdl_on) begin
      checks++;
      if (s !== exp_cur) begin
        failures++;
        $display("FAIL model cyc=%0d actual=%b/%b/%b/%b/%0d required=%b/%b/%b/%b/%0d",
                 cyc, s.idle, s.running, s.done, s.valid, s.val,
                 exp_cur.idle, exp_cur.running, exp_cur.done, exp_cur.valid, exp_cur.val);
      end
    end
    bus.i_run     = run;
    bus.i_num_cnt = n;
    reset_n       = rst_n_in;
    // A job of N cycles is N counting records followed by one done record;
    // a request is only honoured when the block is idle this cycle.
    if (!rst_n_in) begin
      exp_q.delete();
      exp_cur = IDLE_REC;
    end else begin
      if (exp_cur.idle && run) begin
        for (int i = 0; i < int'(n); i++) exp_q.push_back(run_rec(i));
        exp_q.push_back(DONE_REC);
      end
      exp_cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_REC;
    end
    cyc++;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      cycle(1'b0, '0, 1'b1);
      if (s.idle) return;
    end
    chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic run_job(input logic [CW-1:0] n, output int lat, output int nvld, output int last);
    lat = -1; nvld = 0; last = -1;
    cycle(1'b1, n, 1'b1);
    for (int k = 1; k <= 300; k++) begin
      cycle(1'b0, n, 1'b1);
      if (s.valid) begin
        nvld++;
        last = int'(s.val);
      end
      if (s.done) begin
        lat = k;
        break;
      end
    end
  endtask

  vec_t tbl[18];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, nvld, last;
    int d0, d1, nd, first_run;

    bus.i_run     = 1'b0;
    bus.i_num_cnt = '0;
    exp_cur       = IDLE_REC;

    // Reset held 3 edges with i_run high, then a basic N=5 job, N=0 and N=1.
    tbl[0]  = '{1'b0, 1'b1, 7'd5, 1'b0, IDLE_REC};
    tbl[1]  = '{1'b0, 1'b1, 7'd5, 1'b1, IDLE_REC};
    tbl[2]  = '{1'b0, 1'b1, 7'd5, 1'b1, IDLE_REC};
    tbl[3]  = '{1'b1, 1'b0, 7'd5, 1'b1, IDLE_REC};
    tbl[4]  = '{1'b1, 1'b1, 7'd5, 1'b1, IDLE_REC};
    tbl[5]  = '{1'b1, 1'b0, 7'd0, 1'b1, run_rec(0)};
    tbl[6]  = '{1'b1, 1'b0, 7'd0, 1'b1, run_rec(1)};
    tbl[7]  = '{1'b1, 1'b0, 7'd0, 1'b1, run_rec(2)};
    tbl[8]  = '{1'b1, 1'b0, 7'd0, 1'b1, run_rec(3)};
    tbl[9]  = '{1'b1, 1'b0, 7'd0, 1'b1, run_rec(4)};
    tbl[10] = '{1'b1, 1'b0, 7'd0, 1'b1, DONE_REC};
    tbl[11] = '{1'b1, 1'b0, 7'd0, 1'b1, IDLE_REC};
    tbl[12] = '{1'b1, 1'b1, 7'd0, 1'b1, IDLE_REC};
    tbl[13] = '{1'b1, 1'b0, 7'd0, 1'b1, DONE_REC};
    tbl[14] = '{1'b1, 1'b1, 7'd1, 1'b1, IDLE_REC};
    tbl[15] = '{1'b1, 1'b0, 7'd0, 1'b1, run_rec(0)};
    tbl[16] = '{1'b1, 1'b0, 7'd0, 1'b1, DONE_REC};
    tbl[17] = '{1'b1, 1'b0, 7'd0, 1'b1, IDLE_REC};

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].run, tbl[i].n, tbl[i].rst_n);
      if (i == 0) mdl_on = 1'b1;
      if (tbl[i].chk) chk($sformatf("vec%0d", i), int'(s), int'(tbl[i].exp));
    end

    // N=127: full-range count without wrap.
    run_job(7'd127, lat, nvld, last);
    chk("n127_latency", lat, 128);
    chk("n127_valid_cycles", nvld, 127);
    chk("n127_last_val", last, 126);
    wait_idle();

    // Requests ignored during RUN/DONE; the held request starts a new job.
    d0 = -1; first_run = -1;
    cycle(1'b1, 7'd4, 1'b1);
    for (int k = 1; k < 30; k++) begin
      cycle(1'b1, 7'd9, 1'b1);
      if (s.done && d0 < 0) d0 = k;
      if (d0 >= 0 && k > d0 && s.running && first_run < 0) first_run = k;
      if (first_run >= 0) break;
    end
    chk("ignored_first_done", d0, 5);
    chk("ignored_next_run_gap", first_run - d0, 2);
    wait_idle();

    // Back-to-back with i_run held high and N=2.
    d0 = -1; d1 = -1; nd = 0;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 7'd2, 1'b1);
      if (s.done) begin
        nd++;
        if (d0 < 0) d0 = k;
        else if (d1 < 0) d1 = k;
      end
    end
    chk("b2b_done_count", nd, 4);
    chk("b2b_period", d1 - d0, 4);
    wait_idle();

    // Abort with reset in RUN cycle 3, then a normal N=3 job.
    cycle(1'b1, 7'd10, 1'b1);
    cycle(1'b0, 7'd10, 1'b1);
    cycle(1'b0, 7'd10, 1'b1);
    cycle(1'b0, 7'd10, 1'b0);
    chk("abort_run_val", int'(s.val), 2);
    cycle(1'b0, 7'd3, 1'b1);
    chk("abort_idle", int'(s.idle), 1);
    chk("abort_no_done", int'(s.done), 0);
    chk("abort_val_zero", int'(s.val), 0);
    run_job(7'd3, lat, nvld, last);
    chk("post_abort_latency", lat, 4);
    chk("post_abort_valid_cycles", nvld, 3);
    wait_idle();

    // Randomized traffic against the model, with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      logic          r;
      logic [CW-1:0] n;
      logic          rn;
      r  = ($urandom_range(0, 2) == 0);
      n  = ($urandom_range(0, 19) == 0) ? CW'($urandom_range(0, 127)) : CW'($urandom_range(0, 6));
      rn = ($urandom_range(0, 149) != 0);
      cycle(r, n, rn);
      chk("onehot", int'(s.idle) + int'(s.running) + int'(s.done), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
